// File: rtl/ledscroll_monitor.sv
// ledscroll_monitor: receive-side checker for a rotating one-hot LED ring.
// Acquires the lit position and rotation direction from qualified samples,
// then tracks legal single-position moves, counts laps and latches a
// sticky error on any illegal step or malformed sample.
module ledscroll_monitor #(
    parameter int N     = 10,
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     led_in,
    input  logic             step_en,
    input  logic             clr,
    output logic [3:0]       pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             locked,
    output logic [LAP_W-1:0] lap_count,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [3:0]   LAST    = 4'(N - 1);
    localparam logic [N-1:0] ONE_VEC = {{(N-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       pos_d;
    logic             pos_valid_d;
    logic             dir_d;
    logic             locked_d;
    logic             err_d;
    logic [LAP_W-1:0] lap_d;

    logic             legal;
    logic [3:0]       p;
    logic [3:0]       pos_up;
    logic [3:0]       pos_dn;
    logic [3:0]       pos_next;
    logic             wraps;

    // Decode the sampled bus: legal when exactly one bit is set, p is its index.
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        legal = (led_in != '0) && ((led_in & (led_in - ONE_VEC)) == '0);
        p     = '0;
        for (int i = 0; i < N; i++) begin
            if (led_in[i]) begin
                p = 4'(i);
            end
        end
    end

    // Neighbour positions of the current pos on the ring and the wrap condition of the expected step.
    always_comb begin
        pos_up   = (pos == LAST) ? 4'd0 : pos + 4'd1;
        pos_dn   = (pos == 4'd0) ? LAST : pos - 4'd1;
        pos_next = dir ? pos_up : pos_dn;
        wraps    = dir ? (pos == LAST) : (pos == 4'd0);
    end

    // Next-state and next-output logic of the tracking FSM.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos;
        pos_valid_d = pos_valid;
        dir_d       = dir;
        lap_d       = lap_count;
        if (step_en) begin
            unique case (state_q)
                IDLE: begin
                    if (legal) begin
                        state_d     = ACQ;
                        pos_d       = p;
                        pos_valid_d = 1'b1;
                    end
                end
                ACQ: begin
                    if (!legal) begin
                        state_d = ERR;
                    end else if (p == pos_up) begin
                        // For N=2 up and down coincide; up is checked first.
                        state_d = LOCK;
                        dir_d   = 1'b1;
                        pos_d   = p;
                    end else if (p == pos_dn) begin
                        state_d = LOCK;
                        dir_d   = 1'b0;
                        pos_d   = p;
                    end else if (p != pos) begin
                        state_d = ERR;
                    end
                end
                LOCK: begin
                    if (!legal) begin
                        state_d = ERR;
                    end else if (p == pos_next) begin
                        pos_d = p;
                        if (wraps) begin
                            lap_d = lap_count + LAP_W'(1);
                        end
                    end else if (p != pos) begin
                        state_d = ERR;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        locked_d = (state_d == LOCK);
        err_d    = (state_d == ERR);
    end

    // State and output registers; rst has priority over clr, both over sampling.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q   <= IDLE;
            pos       <= '0;
            pos_valid <= 1'b0;
            dir       <= 1'b0;
            locked    <= 1'b0;
            lap_count <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos       <= pos_d;
            pos_valid <= pos_valid_d;
            dir       <= dir_d;
            locked    <= locked_d;
            lap_count <= lap_d;
            err       <= err_d;
        end
    end

endmodule
